// File: rtl/demux_frame_router.sv
// Serial frame front-end for a 1-to-4 demultiplexer with enable.
// Receives a start pulse, a 2-bit MSB-first destination address and then
// PAYLOAD_LEN payload bits, and drives the demux x/en/sel controls so that
// each payload bit reaches only the addressed channel.
module demux_frame_router #(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       din,
  input  logic       din_valid,
  output logic       x,
  output logic       en,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CW-1:0] ADDR_LAST    = CW'(1);
  localparam logic [CW-1:0] PAYLOAD_LAST = CW'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          x_n, en_n;
  logic [1:0]    sel_n;
  logic [1:0]    addr, addr_n;
  logic [CW-1:0] cnt, cnt_n;

  // State and datapath registers; every demux control comes straight from a flop.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= 1'b0;
      en    <= 1'b0;
      sel   <= 2'b00;
      addr  <= 2'b00;
      cnt   <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      en    <= en_n;
      sel   <= sel_n;
      addr  <= addr_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and next-output logic; abort overrides everything else.
  // NOTE: every signal gets a hold default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    x_n     = x;
    en_n    = en;
    sel_n   = sel;
    addr_n  = addr;
    cnt_n   = cnt;
    if (abort) begin
      // Address is deliberately kept; sel keeps pointing at the last channel.
      state_n = IDLE;
      en_n    = 1'b0;
      x_n     = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = ADDR;
            cnt_n   = '0;
          end
        end
        ADDR: begin
          if (din_valid) begin
            addr_n = {addr[0], din};
            if (cnt == ADDR_LAST) begin
              state_n = PAYLOAD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
        PAYLOAD: begin
          if (din_valid) begin
            // sel only ever changes together with en=1 and always to this
            // frame's address, so no other channel sees an enable.
            x_n   = din;
            en_n  = 1'b1;
            sel_n = addr;
            cnt_n = cnt + CW'(1);
            if (cnt == PAYLOAD_LAST) state_n = DONE;
          end else begin
            en_n = 1'b0;
            x_n  = 1'b0;
          end
        end
        DONE: begin
          state_n = IDLE;
          en_n    = 1'b0;
          x_n     = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_demux_frame_router.sv
// Self-checking bench for demux_frame_router: a scoreboard of expected
// (sel, x, done) tuples is filled as payload bits are driven and drained by a
// monitor on every cycle where en is high.
module tb_demux_frame_router;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, abort = 1'b0, din = 1'b0, din_valid = 1'b0;
  logic       x, en, busy, done;
  logic [1:0] sel;

  // Second instance with a one-bit payload for the minimum-length frame.
  logic       s1 = 1'b0, ab1 = 1'b0, d1 = 1'b0, v1 = 1'b0;
  logic       x1, en1, busy1, done1;
  logic [1:0] sel1;

  int vectors = 0;
  int miscompares = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  bit mon_on = 1'b0;

  typedef struct packed {
    logic [1:0] sel;
    logic       x;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  demux_frame_router #(.PAYLOAD_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din),
    .din_valid(din_valid), .x(x), .en(en), .sel(sel), .busy(busy), .done(done)
  );

  demux_frame_router #(.PAYLOAD_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .abort(ab1), .din(d1),
    .din_valid(v1), .x(x1), .en(en1), .sel(sel1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: one expected tuple per en-high cycle.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (en) begin
        en_cnt++;
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("sel", 32'(sel), 32'(mon_e.sel));
          check("x", 32'(x), 32'(mon_e.x));
          check("done", 32'(done), 32'(mon_e.done));
        end
      end else begin
        check("x_while_en_low", 32'(x), 32'd0);
        check("done_while_en_low", 32'(done), 32'd0);
      end
      if (done) done_cnt++;
    end
  end

  // One frame on the 8-bit instance. gap_len>0 inserts invalid cycles after
  // payload bits 2 and 5; abort_after>=0 aborts after that many payload bits.
  task automatic run_frame(input logic [1:0] a, input logic [7:0] p,
                           input int gap_len, input int abort_after,
                           input bit busy_start, input int exp_en);
    int en0 = en_cnt;
    int d0  = done_cnt;
    int n   = (abort_after >= 0) ? abort_after : 8;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 2; i++) begin
      din       = a[1-i];
      din_valid = 1'b1;
      start     = busy_start && (i == 1);
      step();
      start = 1'b0;
      check("addr_en", 32'(en), 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      din       = p[7-i];
      din_valid = 1'b1;
      start     = busy_start && (i == 3);
      sb.push_back('{sel: a, x: p[7-i], done: (i == 7)});
      step();
      start     = 1'b0;
      din_valid = 1'b0;
      if (gap_len > 0 && (i == 1 || i == 4)) begin
        for (int g = 0; g < gap_len; g++) begin
          din = 1'($urandom);
          step();
          check("gap_en", 32'(en), 32'd0);
          check("gap_x", 32'(x), 32'd0);
          check("gap_sel", 32'(sel), 32'(a));
        end
      end
    end
    if (abort_after >= 0) begin
      abort     = 1'b1;
      start     = 1'b1;
      din       = 1'b1;
      din_valid = 1'b1;
      step();
      abort     = 1'b0;
      start     = 1'b0;
      din_valid = 1'b0;
      check("abort_en", 32'(en), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      step();
      check("abort_start_not_queued", 32'(busy), 32'd0);
    end else begin
      check("last_done", 32'(done), 32'd1);
      check("last_busy", 32'(busy), 32'd1);
      step();
      check("post_busy", 32'(busy), 32'd0);
      check("post_en", 32'(en), 32'd0);
      check("post_done", 32'(done), 32'd0);
    end
    check("en_cycles", 32'(en_cnt - en0), 32'(exp_en));
    check("done_pulses", 32'(done_cnt - d0), (abort_after >= 0) ? 32'd0 : 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs, checked before the first clock edge.
    #1;
    rst = 1'b1;
    start = 1'($urandom); abort = 1'($urandom); din = 1'($urandom); din_valid = 1'($urandom);
    s1 = 1'($urandom); d1 = 1'($urandom); v1 = 1'($urandom);
    #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst1_busy", 32'(busy1), 32'd0);
    step();
    step();
    check("rst_hold_busy", 32'(busy), 32'd0);
    check("rst_hold_en", 32'(en), 32'd0);
    start = 1'b0; abort = 1'b0; din = 1'b0; din_valid = 1'b0;
    s1 = 1'b0; d1 = 1'b0; v1 = 1'b0;
    rst = 1'b0;
    mon_on = 1'b1;
    step();

    // Contiguous frame to channel 2.
    run_frame(2'b10, 8'b10110011, 0, -1, 1'b0, 8);
    // Frame with din_valid gaps to channel 1.
    run_frame(2'b01, 8'b11010010, 3, -1, 1'b0, 8);
    // Abort after 4 payload bits to channel 3, then a full frame to channel 0.
    run_frame(2'b11, 8'b10110110, 0, 4, 1'b0, 4);
    check("sel_held_after_abort", 32'(sel), 32'd3);
    run_frame(2'b00, 8'b01100101, 0, -1, 1'b0, 8);
    // Start pulses while busy must not disturb the frame.
    run_frame(2'b10, 8'b11100001, 0, -1, 1'b1, 8);

    // Abort beats start in IDLE.
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    step();
    check("idle_abort_stays", 32'(busy), 32'd0);

    // Async reset in the middle of the payload.
    start = 1'b1;
    step();
    start = 1'b0;
    din_valid = 1'b1;
    din = 1'b1; step();
    din = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      din = 1'b1;
      sb.push_back('{sel: 2'b10, x: 1'b1, done: 1'b0});
      step();
    end
    din_valid = 1'b0;
    check("pre_rst_en", 32'(en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_en", 32'(en), 32'd0);
    check("async_rst_x", 32'(x), 32'd0);
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_idle", 32'(busy), 32'd0);

    // Minimum frame on the one-bit instance: address 11, payload 1.
    s1 = 1'b1;
    step();
    s1 = 1'b0;
    d1 = 1'b1;
    v1 = 1'b1;
    step();
    step();
    check("len1_en_before", 32'(en1), 32'd0);
    step();
    v1 = 1'b0;
    check("len1_en", 32'(en1), 32'd1);
    check("len1_sel", 32'(sel1), 32'd3);
    check("len1_x", 32'(x1), 32'd1);
    check("len1_done", 32'(done1), 32'd1);
    step();
    check("len1_post_en", 32'(en1), 32'd0);
    check("len1_post_busy", 32'(busy1), 32'd0);
    check("len1_post_done", 32'(done1), 32'd0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
